imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-read-port instruction ROM between two requesters: the
//  instruction-fetch unit (IF) and the load unit (LS, for lw from .text).
//  Sits between the multicycle core and instr_rom. Grants one request per cycle.
//  Routes the ROM's 1-cycle-latency registered data back to the owner with a
//  valid pulse. A wait counter guarantees that LS is never starved.
// PARAMETERS
//  ADDR_W    14  byte address width (ROM word index = addr[ADDR_W-1:2])
//  DATA_W    32  instruction/data word width
//  MAX_WAIT  4   max consecutive cycles LS may wait before a forced grant (1..15)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  if_req     in   1       fetch request; held with if_addr stable until if_gnt
//  if_addr    in   ADDR_W  fetch byte address
//  if_gnt     out  1       fetch request accepted this cycle
//  if_rvalid  out  1       one-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetch data
//  ls_req     in   1       load request; held with ls_addr stable until ls_gnt
//  ls_addr    in   ADDR_W  load byte address
//  ls_gnt     out  1       load request accepted this cycle
//  ls_rvalid  out  1       one-cycle pulse: ls_rdata/ls_err valid
//  ls_rdata   out  DATA_W  load data
//  ls_err     out  1       misaligned load (ls_addr[1:0]!=0), qualified by ls_rvalid
//  rom_addr   out  ADDR_W  to ROM i_addr
//  rom_data   in   DATA_W  from ROM o_data (registered, 1-cycle latency)
// BEHAVIOUR
//  - Reset (rst_n=0): if_gnt=ls_gnt=0, if_rvalid=ls_rvalid=0, if_rdata=ls_rdata=0,
//    ls_err=0; owner tag=NONE; wait_cnt=0; rr pointer=IF-first. rom_addr follows if_addr.
//  - Grant (combinational, cycle N): at most one of if_gnt/ls_gnt is high; gnt=req&win.
//    rom_addr = ls_addr if ls_gnt, else if_addr.
//  - Response: cycle N+1 -> <owner>_rvalid=1 for exactly one cycle, rdata=rom_data.
//    No backpressure: the requester must consume the data in that cycle.
//  - Pipelined issue: a new grant is allowed in N+1 while the N response returns.
//    Back-to-back grants therefore give one response per cycle.
//  - rdata = 0 whenever the matching rvalid=0.
//  - Owner tag: registered in cycle N (IF/LS/NONE) and selects the rvalid target in N+1.
//  - Misaligned LS: the load is granted and the ROM read normally. The response has
//    ls_err=1 and ls_rdata=0. Fetch ignores if_addr[1:0].
//  - Out-of-range addresses: the ROM returns 0; passed through, no error.
//  - Starvation: wait_cnt increments each cycle with ls_req=1 and ls_gnt=0.
//    It clears on ls_gnt or when ls_req=0.
//    When wait_cnt==MAX_WAIT, LS wins regardless of the policy.
//  - Reset mid-transaction: the pending response is dropped; no rvalid after
//    reset release until a new grant.
//  - Request dropped before grant: legal. No response is produced.
// CONFIGURATION
//  IMEM_ARB_RR_EN defined: round-robin arbitration.
//  - When both request, the requester not granted last wins.
//  - Pointer updates only on a grant.
//  IMEM_ARB_RR_EN undefined: fixed priority, IF over LS.
//  - LS wins a conflict only via the MAX_WAIT forced grant.
//  - No pointer flop.
// TESTING (ROM model: word0=0x00200193, word1=0x00000293, 61 words)
//  1 IF only: if_req=1, if_addr=0x000 then 0x004 -> if_gnt both cycles.
//    if_rvalid on next 2 cycles, if_rdata=0x00200193, 0x00000293.
//  2 Conflict: both req every cycle, if_addr=0x000, ls_addr=0x004.
//    Fixed: LS granted on cycle 5 (MAX_WAIT=4).
//    RR: grants alternate IF,LS,IF,LS; ls_rdata=0x00000293.
//  3 Misaligned: ls_addr=0x006 -> ls_gnt, next cycle ls_rvalid=1, ls_err=1, ls_rdata=0.
//  4 Out of range: if_addr=0x0F4 -> if_rvalid=1, if_rdata=0x00000000.
//  5 Reset mid-op: assert rst_n=0 the cycle after if_gnt -> if_rvalid stays 0.
//    All outputs 0; after release the first grant goes to IF.
//  6 Idle: no requests for 10 cycles -> no gnt, no rvalid, wait_cnt stays 0.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// imem_port_arbiter_if
//  Bundles the instruction-ROM sharing signals between the fetch unit (IF),
//  the load unit (LS), the ROM and the arbiter.
//  Signals:
//   if_req/if_addr/if_gnt       fetch request, byte address, grant
//   if_rvalid/if_rdata          fetch response pulse and data
//   ls_req/ls_addr/ls_gnt       load request, byte address, grant
//   ls_rvalid/ls_rdata/ls_err   load response pulse, data, misaligned flag
//   rom_addr/rom_data           ROM read address and registered ROM data
//  Modports:
//   slave  - the arbiter side
//   master - the requester/ROM environment side
// ----------------------------------------------------------------------------
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  if_req, if_addr, ls_req, ls_addr, rom_data,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output rom_addr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_addr, rom_data,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  rom_addr
    );
endinterface : imem_port_arbiter_if

// File: rtl/imem_port_arbiter.sv
// ----------------------------------------------------------------------------
// imem_port_arbiter
//  Shares the single read port of the instruction ROM between the fetch unit
//  (IF) and the load unit (LS). One request is granted per cycle; the ROM's
//  registered data comes back the following cycle and is steered to the owner
//  with a one-cycle rvalid pulse. A wait counter forces an LS grant after
//  MAX_WAIT consecutive losing cycles so LS is never starved.
//
//  Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    imem_port_arbiter_if.slave (IF/LS handshakes, responses, ROM port)
//
//  Parameters:
//   ADDR_W    byte address width (ROM word index = addr[ADDR_W-1:2])
//   DATA_W    data word width
//   MAX_WAIT  LS wait limit before a forced grant, 1..15
//
//  Configuration macro:
//   IMEM_ARB_RR_EN  defined   -> round-robin between IF and LS
//                   undefined -> fixed priority, IF over LS
// ----------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic                clk,
    input logic                rst_n,
    imem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam logic [3:0]        MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [DATA_W-1:0] ZERO_DATA  = {DATA_W{1'b0}};

    owner_e      owner_q, owner_d;
    logic        err_q, err_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic              force_ls_s;
    logic              ls_win_s;
    logic              if_gnt_s;
    logic              ls_gnt_s;
    logic [ADDR_W-1:0] rom_addr_s;
    logic              if_rvalid_s;
    logic [DATA_W-1:0] if_rdata_s;
    logic              ls_rvalid_s;
    logic [DATA_W-1:0] ls_rdata_s;
    logic              ls_err_s;

`ifdef IMEM_ARB_RR_EN
    // 1 = LS held the port last, so IF wins the next conflict.
    logic rr_ls_last_q, rr_ls_last_d;
`endif

    // State registers: owner tag, misaligned flag, LS wait counter, RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_NONE;
            err_q        <= 1'b0;
            wait_cnt_q   <= 4'd0;
`ifdef IMEM_ARB_RR_EN
            // Reset value makes IF win the first conflict.
            rr_ls_last_q <= 1'b1;
`endif
        end else begin
            owner_q      <= owner_d;
            err_q        <= err_d;
            wait_cnt_q   <= wait_cnt_d;
`ifdef IMEM_ARB_RR_EN
            rr_ls_last_q <= rr_ls_last_d;
`endif
        end
    end

    // Arbitration and next-state logic for the owner tag, wait counter, pointer.
    always_comb begin
        force_ls_s = bus.ls_req && (wait_cnt_q == MAX_WAIT_C);
`ifdef IMEM_ARB_RR_EN
        ls_win_s   = force_ls_s || !bus.if_req || !rr_ls_last_q;
`else
        ls_win_s   = force_ls_s || !bus.if_req;
`endif
        // Grants are held low while reset is asserted.
        ls_gnt_s   = rst_n && bus.ls_req && ls_win_s;
        if_gnt_s   = rst_n && bus.if_req && !ls_win_s;

        if (ls_gnt_s) begin
            owner_d = OWN_LS;
        end else if (if_gnt_s) begin
            owner_d = OWN_IF;
        end else begin
            owner_d = OWN_NONE;
        end

        // The ROM read still happens for a misaligned load; only the response is flagged.
        err_d = ls_gnt_s && (bus.ls_addr[1:0] != 2'b00);

        if (bus.ls_req && !ls_gnt_s) begin
            // Saturate defensively; a forced grant normally clears it first.
            if (wait_cnt_q == 4'hF) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end else begin
            wait_cnt_d = 4'd0;
        end

`ifdef IMEM_ARB_RR_EN
        if (ls_gnt_s) begin
            rr_ls_last_d = 1'b1;
        end else if (if_gnt_s) begin
            rr_ls_last_d = 1'b0;
        end else begin
            rr_ls_last_d = rr_ls_last_q;
        end
`endif
    end

    // Output decode: ROM address mux and response steering by the owner tag.
    always_comb begin
        rom_addr_s  = ls_gnt_s ? bus.ls_addr : bus.if_addr;
        if_rvalid_s = 1'b0;
        if_rdata_s  = ZERO_DATA;
        ls_rvalid_s = 1'b0;
        ls_rdata_s  = ZERO_DATA;
        ls_err_s    = 1'b0;
        case (owner_q)
            OWN_IF: begin
                if_rvalid_s = 1'b1;
                if_rdata_s  = bus.rom_data;
            end
            OWN_LS: begin
                ls_rvalid_s = 1'b1;
                ls_err_s    = err_q;
                ls_rdata_s  = err_q ? ZERO_DATA : bus.rom_data;
            end
            default: begin
                if_rvalid_s = 1'b0;
                ls_rvalid_s = 1'b0;
            end
        endcase
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.ls_gnt    = ls_gnt_s;
    assign bus.rom_addr  = rom_addr_s;
    assign bus.if_rvalid = if_rvalid_s;
    assign bus.if_rdata  = if_rdata_s;
    assign bus.ls_rvalid = ls_rvalid_s;
    assign bus.ls_rdata  = ls_rdata_s;
    assign bus.ls_err    = ls_err_s;

endmodule : imem_port_arbiter

// File: tb/tb_imem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_imem_port_arbiter
//  Table-driven bench for imem_port_arbiter with a behavioural 61-word ROM.
//  Each table row is one cycle of requests plus the expected grants and ROM
//  address; the expected response for the following cycle is pushed to a
//  scoreboard queue and compared when that cycle is sampled.
// ----------------------------------------------------------------------------
module tb_imem_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    imem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] rom_word(input logic [11:0] idx);
        if (idx == 12'd0)       return 32'h0020_0193;
        else if (idx == 12'd1)  return 32'h0000_0293;
        else if (idx < 12'd61)  return 32'hA500_0000 | {20'd0, idx};
        else                    return 32'h0000_0000;
    endfunction

    // ROM model: registered read, one-cycle latency.
    always_ff @(posedge clk) begin
        bus.rom_data <= rom_word(bus.rom_addr[13:2]);
    end

    typedef struct {
        logic        if_req;
        logic [13:0] if_addr;
        logic        ls_req;
        logic [13:0] ls_addr;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic [13:0] e_rom_addr;
    } vec_t;

    typedef struct {
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        ls_rvalid;
        logic [31:0] ls_rdata;
        logic        ls_err;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic ir, input logic [13:0] ia, input logic lr,
                       input logic [13:0] la, input logic eig, input logic elg,
                       input logic [13:0] era);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_addr = la;
        v.e_if_gnt = eig; v.e_ls_gnt = elg; v.e_rom_addr = era;
        vecs.push_back(v);
    endtask

    function automatic rsp_t zero_rsp();
        rsp_t r;
        r.if_rvalid = 1'b0; r.if_rdata = 32'd0;
        r.ls_rvalid = 1'b0; r.ls_rdata = 32'd0; r.ls_err = 1'b0;
        return r;
    endfunction

    task automatic check_rsp(input string tag);
        rsp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard actual=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " if_rvalid"}, {31'd0, bus.if_rvalid}, {31'd0, e.if_rvalid});
            check({tag, " if_rdata"},  bus.if_rdata,           e.if_rdata);
            check({tag, " ls_rvalid"}, {31'd0, bus.ls_rvalid}, {31'd0, e.ls_rvalid});
            check({tag, " ls_rdata"},  bus.ls_rdata,           e.ls_rdata);
            check({tag, " ls_err"},    {31'd0, bus.ls_err},    {31'd0, e.ls_err});
        end
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later.
    task automatic apply(input vec_t v, input string tag);
        rsp_t r;
        @(negedge clk);
        bus.if_req  = v.if_req;  bus.if_addr = v.if_addr;
        bus.ls_req  = v.ls_req;  bus.ls_addr = v.ls_addr;
        #1;
        check({tag, " if_gnt"},   {31'd0, bus.if_gnt}, {31'd0, v.e_if_gnt});
        check({tag, " ls_gnt"},   {31'd0, bus.ls_gnt}, {31'd0, v.e_ls_gnt});
        check({tag, " rom_addr"}, {18'd0, bus.rom_addr}, {18'd0, v.e_rom_addr});
        check_rsp(tag);
        r = zero_rsp();
        if (v.e_if_gnt) begin
            r.if_rvalid = 1'b1;
            r.if_rdata  = rom_word(v.if_addr[13:2]);
        end
        if (v.e_ls_gnt) begin
            r.ls_rvalid = 1'b1;
            r.ls_err    = (v.ls_addr[1:0] != 2'b00);
            r.ls_rdata  = r.ls_err ? 32'd0 : rom_word(v.ls_addr[13:2]);
        end
        sb.push_back(r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " if_gnt"},    {31'd0, bus.if_gnt},    32'd0);
        check({tag, " ls_gnt"},    {31'd0, bus.ls_gnt},    32'd0);
        check({tag, " if_rvalid"}, {31'd0, bus.if_rvalid}, 32'd0);
        check({tag, " ls_rvalid"}, {31'd0, bus.ls_rvalid}, 32'd0);
        check({tag, " if_rdata"},  bus.if_rdata,           32'd0);
        check({tag, " ls_rdata"},  bus.ls_rdata,           32'd0);
        check({tag, " ls_err"},    {31'd0, bus.ls_err},    32'd0);
        check({tag, " rom_addr"},  {18'd0, bus.rom_addr},  {18'd0, bus.if_addr});
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 14'h010;
        bus.ls_req = 1'b1; bus.ls_addr = 14'h020;

        // Reset state with both requests raised: nothing may be granted.
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        // Stimulus table.
        add(1'b1, 14'h000, 1'b0, 14'h000, 1'b1, 1'b0, 14'h000);  // IF only word0
        add(1'b1, 14'h004, 1'b0, 14'h000, 1'b1, 1'b0, 14'h004);  // IF only word1
        add(1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0, 14'h000);
        add(1'b0, 14'h000, 1'b1, 14'h006, 1'b0, 1'b1, 14'h006);  // misaligned load
        add(1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0, 14'h000);
        add(1'b1, 14'h0F4, 1'b0, 14'h000, 1'b1, 1'b0, 14'h0F4);  // out of range
        add(1'b1, 14'h005, 1'b0, 14'h000, 1'b1, 1'b0, 14'h005);  // fetch ignores [1:0]
        add(1'b0, 14'h000, 1'b1, 14'h008, 1'b0, 1'b1, 14'h008);  // LS only word2
        // Conflict: both request every cycle.
`ifdef IMEM_ARB_RR_EN
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) add(1'b1, 14'h000, 1'b1, 14'h004, 1'b1, 1'b0, 14'h000);
            else            add(1'b1, 14'h000, 1'b1, 14'h004, 1'b0, 1'b1, 14'h004);
        end
`else
        for (int i = 0; i < 6; i++) begin
            if (i == 4) add(1'b1, 14'h000, 1'b1, 14'h004, 1'b0, 1'b1, 14'h004);
            else        add(1'b1, 14'h000, 1'b1, 14'h004, 1'b1, 1'b0, 14'h000);
        end
`endif
        add(1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0, 14'h000);
        // LS request dropped before it is granted: no response.
        add(1'b1, 14'h000, 1'b1, 14'h00C, 1'b1, 1'b0, 14'h000);
        add(1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0, 14'h000);
        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) add(1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0, 14'h000);
`ifdef IMEM_ARB_RR_EN
        add(1'b1, 14'h008, 1'b1, 14'h00C, 1'b0, 1'b1, 14'h00C);  // IF won last
`else
        add(1'b1, 14'h008, 1'b1, 14'h00C, 1'b1, 1'b0, 14'h008);  // counter cleared
`endif
        add(1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0, 14'h000);

        // Release reset and run the table.
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        bus.if_addr = 14'h000; bus.ls_addr = 14'h000;
        rst_n = 1'b1;
        sb.push_back(zero_rsp());
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Reset mid-transaction: grant IF, then reset before the response is seen.
        add(1'b1, 14'h004, 1'b0, 14'h000, 1'b1, 1'b0, 14'h004);
        apply(vecs[vecs.size()-1], "midrst_gnt");
        @(negedge clk);
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 14'h004;
        bus.ls_req = 1'b0; bus.ls_addr = 14'h000;
        #1;
        check_reset_outputs("midrst_a");
        sb.delete();
        @(negedge clk);
        #1;
        check_reset_outputs("midrst_b");
        bus.if_req = 1'b0;
        rst_n = 1'b1;
        sb.push_back(zero_rsp());
        // First cycles after release: no stale response; first conflict goes to IF.
        v.if_req = 1'b0; v.if_addr = 14'h000; v.ls_req = 1'b0; v.ls_addr = 14'h000;
        v.e_if_gnt = 1'b0; v.e_ls_gnt = 1'b0; v.e_rom_addr = 14'h000;
        apply(v, "post_idle");
        v.if_req = 1'b1; v.if_addr = 14'h000; v.ls_req = 1'b1; v.ls_addr = 14'h004;
        v.e_if_gnt = 1'b1; v.e_ls_gnt = 1'b0; v.e_rom_addr = 14'h000;
        apply(v, "post_first");
        v.if_req = 1'b0; v.ls_req = 1'b0;
        v.e_if_gnt = 1'b0; v.e_ls_gnt = 1'b0; v.e_rom_addr = 14'h000;
        apply(v, "post_rsp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_imem_port_arbiter
